// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural N/Z/V flag register plus a branch-condition
// resolver. A flag write from the instruction in execute is forwarded to the
// branch sitting in decode in the same cycle. The resolver returns a
// registered one-cycle resolution pulse to the fetch/PC logic.
module flag_branch_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] alu_flag,
  input  logic [2:0] alu_op,
  input  logic       ex_valid,
  input  logic       br_valid,
  input  logic [2:0] br_ccc,
  input  logic       stall,
  input  logic       flush,
  output logic [2:0] flags,
  output logic       br_resolved,
  output logic       br_taken
);

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_RED    = 3'b010;
  localparam logic [2:0] OP_XOR    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    RESOLVE = 1'b1
  } state_t;

  state_t     state_q;
  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic       taken_q;
  logic       resolved_q;

  logic       wr;
  logic       cap;
  logic [2:0] wmask;
  logic [2:0] nf;
  logic       cond;

  // Evaluate a condition code against an [N Z V] flag vector.
  function automatic logic eval_ccc(input logic [2:0] ccc, input logic [2:0] f);
    logic n;
    logic z;
    logic v;
    logic r;
    n = f[2];
    z = f[1];
    v = f[0];
    case (ccc)
      3'b000:  r = ~z;
      3'b001:  r = z;
      3'b010:  r = ~z & ~n;
      3'b011:  r = n;
      3'b100:  r = z | (~z & ~n);
      3'b101:  r = n | z;
      3'b110:  r = v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Write/capture qualifiers, per-opcode flag masks and the bypassed next flags.
  always_comb begin
    wr    = ex_valid & ~stall & ~flush;
    cap   = br_valid & ~stall & ~flush;
    wmask = 3'b000;
    case (alu_op)
      OP_ADD, OP_SUB:                 wmask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: wmask = 3'b010;
      OP_RED, OP_PADDSB:              wmask = 3'b000;
      default:                        wmask = 3'b000;
    endcase
    nf      = wr ? ((alu_flag & wmask) | (flags_q & ~wmask)) : flags_q;
    // nf already equals flags_q whenever stall is high, so the register holds.
    flags_d = nf;
    // Branch sees the post-write flags of the instruction currently in execute.
    cond    = eval_ccc(br_ccc, nf);
  end

  // Architectural flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Resolver FSM with registered resolution pulse and taken result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      resolved_q <= 1'b0;
      taken_q    <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        IDLE, RESOLVE: begin
          if (cap) begin
            state_q    <= RESOLVE;
            resolved_q <= 1'b1;
            taken_q    <= cond;
          end else begin
            state_q    <= IDLE;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          resolved_q <= 1'b0;
          taken_q    <= 1'b0;
        end
      endcase
    end
  end

  assign flags       = flags_q;
  assign br_resolved = resolved_q;
  assign br_taken    = taken_q;

endmodule
